// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, runs a single-outstanding SRAM-like
// instruction bus and hands fetched words to ID, discarding responses made stale by redirects.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] pc_o,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        cancel_reg, cancel_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_inst_reg, if_inst_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= ST_REQ;
      pc_reg      <= RESET_PC;
      cancel_reg  <= 1'b0;
      if_pc_reg   <= 32'd0;
      if_inst_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      cancel_reg  <= cancel_next;
      if_pc_reg   <= if_pc_next;
      if_inst_reg <= if_inst_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    cancel_next  = cancel_reg;
    if_pc_next   = if_pc_reg;
    if_inst_next = if_inst_reg;
    case (state_reg)
      ST_REQ: begin
        // An unaccepted address may be retargeted freely; an accepted one must be cancelled.
        if (redirect_i) pc_next = redirect_pc_i;
        if (inst_addr_ok_i) begin
          state_next  = ST_WAIT;
          cancel_next = redirect_i;
        end
      end
      ST_WAIT: begin
        if (inst_data_ok_i) begin
          if (cancel_reg || redirect_i) begin
            cancel_next = 1'b0;
            state_next  = ST_REQ;
            if (redirect_i) pc_next = redirect_pc_i;
          end else begin
            if_inst_next = inst_rdata_i;
            if_pc_next   = pc_reg;
            state_next   = ST_HOLD;
          end
        end else if (redirect_i) begin
          pc_next     = redirect_pc_i;
          cancel_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_next    = redirect_pc_i;
          state_next = ST_REQ;
        end else if (!stall_i) begin
          pc_next    = pc_reg + 32'd4;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  assign inst_req_o  = (state_reg == ST_REQ);
  assign inst_addr_o = pc_reg;
  assign pc_o        = pc_reg;
  assign if_valid_o  = (state_reg == ST_HOLD);
  assign if_pc_o     = if_pc_reg;
  assign if_inst_o   = if_inst_reg;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: cycle vectors with expected outputs, plus a delivery scoreboard
// fed at request acceptance and drained when ID sees a new valid instruction.
module tb_if_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = 32'd0;
  logic [31:0] pc_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  if_fetch_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .pc_o           (pc_o),
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        aok;
    logic        dok;
    logic        dl;
    logic        er;
    logic [31:0] ea;
    logic        ev;
    logic [31:0] ep;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_addr = 32'd0;
  logic        held = 1'b0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic aok, logic dok,
                              logic dl, logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.aok = aok; v.dok = dok; v.dl = dl;
    v.er = er; v.ea = ea; v.ev = ev; v.ep = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Compare this cycle's outputs, drive this cycle's inputs, advance one clock.
  task automatic apply_row(vec_t v, int idx);
    logic held_next;
    chk($sformatf("row%0d req", idx), {31'd0, inst_req_o}, {31'd0, v.er});
    chk($sformatf("row%0d addr", idx), inst_addr_o, v.ea);
    chk($sformatf("row%0d pc", idx), pc_o, v.ea);
    chk($sformatf("row%0d valid", idx), {31'd0, if_valid_o}, {31'd0, v.ev});
    if (v.ev) begin
      chk($sformatf("row%0d if_pc", idx), if_pc_o, v.ep);
      chk($sformatf("row%0d if_inst", idx), if_inst_o, mem_word(v.ep));
    end
    if (if_valid_o && !held) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL row%0d sb_underflow: got delivery pc %08h expected none", idx, if_pc_o);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk($sformatf("row%0d sb_pc", idx), if_pc_o, e);
        chk($sformatf("row%0d sb_inst", idx), if_inst_o, mem_word(e));
      end
    end
    held_next = if_valid_o && v.st && !v.rd;
    stall_i        = v.st;
    redirect_i     = v.rd;
    redirect_pc_i  = v.rd ? v.rpc : $urandom;
    inst_addr_ok_i = v.aok;
    inst_data_ok_i = v.dok;
    inst_rdata_i   = v.dok ? mem_word(acc_addr) : $urandom;
    if (v.aok && v.er) acc_addr = v.ea;
    if (v.dl) sb.push_back(v.ea);
    @(posedge clk_i);
    #1;
    held = held_next;
    $display("row %0d: req=%0b addr=%08h valid=%0b if_pc=%08h", idx, inst_req_o, inst_addr_o,
             if_valid_o, if_pc_o);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // st rd rpc aok dok dl | er addr valid if_pc
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'hBFC0_0000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'hBFC0_0000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 1, 32'hBFC0_0000));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'hBFC0_0004, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'hBFC0_0004, 0, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0004));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0004));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'hBFC0_0008, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'hBFC0_0008, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 1, 32'hBFC0_0008));
    // redirect while waiting; stale data arrives two cycles later
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'hBFC0_000C, 0, 0));
    vq.push_back(mk(0, 1, 32'h8000_1000, 0, 0, 0, 0, 32'hBFC0_000C, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_1000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h8000_1000, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h8000_1000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h8000_1000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_1000, 1, 32'h8000_1000));
    // redirect while the bus withholds addr_ok
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_1004, 0, 0));
    vq.push_back(mk(0, 1, 32'h8000_2000, 0, 0, 0, 1, 32'h8000_1004, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_2000, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h8000_2000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h8000_2000, 0, 0));
    // redirect and stall together in HOLD
    vq.push_back(mk(1, 1, 32'h8000_3000, 0, 0, 0, 0, 32'h8000_2000, 1, 32'h8000_2000));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h8000_3000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h8000_3000, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h8000_3000, 1, 32'h8000_3000));
    vq.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h8000_3000, 1, 32'h8000_3000));
    // PC wrap
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h0000_0000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_0000));
    // redirect in the same cycle the address is accepted
    vq.push_back(mk(0, 1, 32'h8000_5000, 1, 0, 0, 1, 32'h0000_0004, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h8000_5000, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h8000_5000, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h8000_5000, 0, 0));
    // stray data_ok outside WAIT is ignored
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'h8000_5000, 1, 32'h8000_5000));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_5000, 1, 32'h8000_5000));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h8000_5004, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h8000_5004, 0, 0));

    #3 rst_i = 1'b0;
    #1;
    chk("reset pc", pc_o, 32'hBFC0_0000);
    chk("reset valid", {31'd0, if_valid_o}, 32'd0);
    chk("reset if_pc", if_pc_o, 32'd0);
    chk("reset if_inst", if_inst_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply_row(vq[i], i);

    // reset asserted while a request is outstanding
    chk("wait req", {31'd0, inst_req_o}, 32'd0);
    chk("sb drained", sb.size(), 32'd0);
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("midreset pc", pc_o, 32'hBFC0_0000);
    chk("midreset req", {31'd0, inst_req_o}, 32'd1);
    chk("midreset valid", {31'd0, if_valid_o}, 32'd0);
    chk("midreset if_pc", if_pc_o, 32'd0);
    chk("midreset if_inst", if_inst_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    held = 1'b0;
    apply_row(mk(0, 0, 0, 1, 0, 1, 1, 32'hBFC0_0000, 0, 0), 100);
    apply_row(mk(0, 0, 0, 0, 1, 0, 0, 32'hBFC0_0000, 0, 0), 101);
    apply_row(mk(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 1, 32'hBFC0_0000), 102);
    chk("sb empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer for the IF stage. Owns the fetch PC and drives an SRAM-like instruction bus (separate address and data handshakes). Allows at most one outstanding request and hands each fetched instruction to ID with a valid flag. Handles decode stalls and branch/exception redirects, including discarding in-flight responses that a redirect has made stale.

## Interface
- RESET_PC, 32'hBFC0_0000, fetch address issued first after reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  ID cannot accept the instruction held on if_*_o
- redirect_i  in  1  branch/exception redirect, single-cycle pulse
- redirect_pc_i  in  32  redirect target, sampled when redirect_i=1
- inst_req_o  out  1  address-phase request
- inst_addr_o  out  32  request address (= pc_o)
- inst_addr_ok_i  in  1  address accepted this cycle
- inst_data_ok_i  in  1  read data valid this cycle
- inst_rdata_i  in  32  read data
- pc_o  out  32  current fetch PC
- if_valid_o  out  1  if_pc_o/if_inst_o hold a valid instruction
- if_pc_o  out  32  PC of delivered instruction
- if_inst_o  out  32  delivered instruction

## Operation
- State register: REQ, WAIT, HOLD. Separate cancel flag. pc_o register.
- Reset (rst_i=0): state=REQ, pc_o=RESET_PC, cancel=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
- inst_req_o=1 only in REQ. inst_addr_o=pc_o. if_valid_o=1 only in HOLD.
- REQ:
  - addr_ok=1, no redirect: go to WAIT.
  - addr_ok=1 and redirect: pc_o<=redirect_pc_i, cancel<=1, go to WAIT.
  - addr_ok=0 and redirect: pc_o<=redirect_pc_i, stay in REQ. The address may change because it was not accepted.
- WAIT:
  - data_ok=1, cancel=0, no redirect: capture if_inst_o<=inst_rdata_i and if_pc_o<=pc_o, go to HOLD.
  - data_ok=1 and (cancel=1 or redirect): drop the data, cancel<=0, go to REQ. On redirect, pc_o<=redirect_pc_i.
  - data_ok=0 and redirect: pc_o<=redirect_pc_i, cancel<=1, stay in WAIT. Repeated redirects overwrite pc_o; cancel stays 1.
- HOLD:
  - redirect: drop the held instruction, pc_o<=redirect_pc_i, go to REQ.
  - stall_i=1, no redirect: hold all outputs unchanged.
  - stall_i=0, no redirect: instruction consumed this cycle; pc_o<=pc_o+4, go to REQ.
- Redirect has priority over stall. PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect target alignment is not checked; the target is passed through unchanged.
- inst_data_ok_i outside WAIT is a bus protocol violation. It is ignored with no state change.

## Timing
- All state and outputs are registered; no combinational path from bus inputs to outputs except none. inst_req_o depends only on state.
- First request is issued the cycle after rst_i deasserts, with inst_addr_o=RESET_PC.
- Best-case delivery, with addr_ok in the request cycle T and data_ok at T+1: if_valid_o=1 at T+2. The next request is at T+3 if not stalled. Throughput is one instruction per 3 cycles.
- A redirect in cycle T takes effect on pc_o at T+1.
- A stale response is never presented: if_valid_o stays 0 from the redirect until the first data of the redirected fetch.
- Reset asserted mid-operation returns to reset values immediately, regardless of outstanding bus transactions. The bench must not return data_ok for a pre-reset request.

## Test plan
- Reset, memory with zero wait: addr_ok=1 and data_ok on the next cycle -> inst_addr_o sequence BFC00000, BFC00004, BFC00008. if_valid_o pulses with if_pc_o matching and if_inst_o=memory word.
- Hold stall_i=1 for 5 cycles while in HOLD at pc BFC00004 -> if_* stable, inst_req_o=0. Release -> next inst_addr_o=BFC00008.
- redirect_i to 80001000 while in WAIT; old data_ok arrives 2 cycles later -> old word never on if_inst_o. Next request addr=80001000, delivered with if_pc_o=80001000.
- redirect_i with addr_ok=0 in REQ (bus holds addr_ok low 3 cycles) -> inst_addr_o switches to target next cycle. It is accepted with no cancel, and the first delivered PC is the target.
- redirect_i and stall_i both high in HOLD -> held instruction dropped, inst_req_o=1 at target the next cycle.
- rst_i pulled low in WAIT, then released -> all outputs at reset values, first request BFC00000. Also check FFFFFFFC+4 wraps to 00000000 after a redirect to FFFFFFFC.
